// File: rtl/icache_if.sv
// Fetch-stage and memory-controller signals seen by the instruction cache.
// The cache takes the slave side; the fetch stage and controller take the master side.
interface icache_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_inst_valid;
  logic [31:0] if_inst;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic        mc_enable;
  logic [31:0] mc_inst;
  logic        jump_flag;

  modport slave (
    input  if_req,
    input  if_pc,
    input  mc_enable,
    input  mc_inst,
    input  jump_flag,
    output if_inst_valid,
    output if_inst,
    output mc_valid,
    output mc_addr
  );

  modport master (
    output if_req,
    output if_pc,
    output mc_enable,
    output mc_inst,
    output jump_flag,
    input  if_inst_valid,
    input  if_inst,
    input  mc_valid,
    input  mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines and a single outstanding miss.
// Defining ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_next;

  logic [LINES-1:0]    line_valid;
  logic [TAG_BITS-1:0] line_tag  [LINES];
  logic [31:0]         line_data [LINES];

  logic        inst_valid_q, inst_valid_next;
  logic [31:0] inst_q, inst_next;
  logic        mc_valid_q, mc_valid_next;
  logic [31:0] mc_addr_q, mc_addr_next;
  logic        fill, hit_event, miss_event;

  logic [INDEX_BITS-1:0] req_index, fill_index;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;
  logic                  unused_pc_bits;

  // The outstanding miss address lives in mc_addr_q, so the fill reuses it.
  assign req_index      = bus.if_pc[INDEX_BITS+1:2];
  assign req_tag        = bus.if_pc[31:INDEX_BITS+2];
  assign fill_index     = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag       = mc_addr_q[31:INDEX_BITS+2];
  assign hit            = line_valid[req_index] && (line_tag[req_index] == req_tag);
  assign unused_pc_bits = ^bus.if_pc[1:0];

  always_comb begin
    state_next      = state;
    inst_valid_next = 1'b0;
    inst_next       = inst_q;
    mc_valid_next   = mc_valid_q;
    mc_addr_next    = mc_addr_q;
    fill            = 1'b0;
    hit_event       = 1'b0;
    miss_event      = 1'b0;
    if (bus.jump_flag) begin
      // A flush wins over everything, including a same-cycle mc_enable.
      state_next    = IDLE;
      mc_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req) begin
            if (hit) begin
              inst_valid_next = 1'b1;
              inst_next       = line_data[req_index];
              hit_event       = 1'b1;
            end else begin
              mc_valid_next = 1'b1;
              mc_addr_next  = {bus.if_pc[31:2], 2'b00};
              state_next    = MISS;
              miss_event    = 1'b1;
            end
          end
        end
        MISS: begin
          if (bus.mc_enable) begin
            fill            = 1'b1;
            inst_valid_next = 1'b1;
            inst_next       = bus.mc_inst;
            mc_valid_next   = 1'b0;
            state_next      = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      mc_valid_q   <= 1'b0;
      mc_addr_q    <= '0;
    end else if (rdy) begin
      state        <= state_next;
      inst_valid_q <= inst_valid_next;
      inst_q       <= inst_next;
      mc_valid_q   <= mc_valid_next;
      mc_addr_q    <= mc_addr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (rdy && fill) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= bus.mc_inst;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy) begin
      if (hit_event && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (miss_event && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_stats_events;
  assign unused_stats_events = hit_event ^ miss_event;
`endif

  // A held pulse is masked while stalled and shows again once rdy returns.
  assign bus.if_inst_valid = inst_valid_q & rdy;
  assign bus.if_inst       = inst_q;
  assign bus.mc_valid      = mc_valid_q;
  assign bus.mc_addr       = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: a word-address model of the cache predicts hits and misses,
// the driver queues expected instructions/fetch addresses, and a negedge monitor checks them.
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  icache_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(.INDEX_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] mem [bit [31:0]];
  bit          mvalid [256];
  bit [31:0]   mline  [256];
  int          exp_hits;
  int          exp_misses;
  logic [31:0] exp_inst [$];
  logic [31:0] exp_req  [$];
  int          pulse_cyc [$];

  function automatic logic [31:0] memWord(input logic [31:0] pc);
    bit [31:0] word;
    word = {pc[31:2], 2'b00};
    if (!mem.exists(word)) mem[word] = $urandom;
    return mem[word];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkStats();
`ifdef ICACHE_STATS_EN
    checkOutput("hit_count", hit_count, exp_hits);
    checkOutput("miss_count", miss_count, exp_misses);
`endif
  endtask

  task automatic resetDut();
    rst = 1'b0;
    rdy = 1'b1;
    bus.if_req = 1'b0;
    bus.if_pc = '0;
    bus.mc_enable = 1'b0;
    bus.mc_inst = '0;
    bus.jump_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_if_inst_valid", bus.if_inst_valid, 0);
    checkOutput("reset_if_inst", bus.if_inst, 0);
    checkOutput("reset_mc_valid", bus.mc_valid, 0);
    checkOutput("reset_mc_addr", bus.mc_addr, 0);
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    checkStats();
    rst = 1'b1;
  endtask

  task automatic idleCycle();
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One fetch; flush_at < lat flushes mid-miss, flush_at == lat flushes with mc_enable.
  task automatic applyStimulus(input logic [31:0] pc, input int lat, input int flush_at);
    int idx;
    logic [31:0] word, data;
    bit flushed;
    idx = int'(pc[9:2]);
    word = {pc[31:2], 2'b00};
    data = memWord(pc);
    flushed = 1'b0;
    bus.if_req = 1'b1;
    bus.if_pc = pc;
    if (mvalid[idx] && mline[idx] == word) begin
      exp_inst.push_back(data);
      exp_hits++;
      @(posedge clk);
      #1;
      checkOutput("hit_latency", bus.if_inst_valid, 1);
      checkOutput("hit_no_mc_valid", bus.mc_valid, 0);
    end else begin
      exp_req.push_back(word);
      exp_misses++;
      @(posedge clk);
      #1;
      checkOutput("miss_mc_valid", bus.mc_valid, 1);
      for (int i = 0; i < lat && !flushed; i++) begin
        if (i == flush_at) begin
          bus.jump_flag = 1'b1;
          @(posedge clk);
          #1;
          bus.jump_flag = 1'b0;
          bus.if_req = 1'b0;
          checkOutput("flush_mc_valid_drop", bus.mc_valid, 0);
          checkOutput("flush_no_inst", bus.if_inst_valid, 0);
          flushed = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
      if (!flushed) begin
        bus.mc_enable = 1'b1;
        bus.mc_inst = data;
        if (flush_at == lat) bus.jump_flag = 1'b1;
        else exp_inst.push_back(data);
        @(posedge clk);
        #1;
        bus.mc_enable = 1'b0;
        bus.mc_inst = $urandom;
        if (flush_at == lat) begin
          bus.jump_flag = 1'b0;
          bus.if_req = 1'b0;
          checkOutput("coincident_mc_valid_drop", bus.mc_valid, 0);
          checkOutput("coincident_no_inst", bus.if_inst_valid, 0);
        end else begin
          checkOutput("fill_inst_valid", bus.if_inst_valid, 1);
          checkOutput("fill_mc_valid_drop", bus.mc_valid, 0);
          mvalid[idx] = 1'b1;
          mline[idx] = word;
        end
      end
    end
  endtask

  // Four warm words requested back to back with a two-cycle rdy stall after the second.
  task automatic streamWithStall(input logic [31:0] base);
    for (int i = 0; i < 4; i++) applyStimulus(base + 32'(4 * i), 2, -1);
    idleCycle();
    pulse_cyc.delete();
    bus.if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.if_pc = base + 32'(4 * i);
      exp_inst.push_back(memWord(bus.if_pc));
      exp_hits++;
      if (i == 2) begin
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rdy = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stream_pulse_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() == 4) begin
      checkOutput("stream_gap_stall", pulse_cyc[1] - pulse_cyc[0], 3);
      checkOutput("stream_gap_2", pulse_cyc[2] - pulse_cyc[1], 1);
      checkOutput("stream_gap_3", pulse_cyc[3] - pulse_cyc[2], 1);
    end
    checkStats();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic prev_mc;
    logic [31:0] prev_pc, held_addr;
    prev_mc = 1'b0;
    prev_pc = '0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_mc = 1'b0;
      end else begin
        if (bus.if_inst_valid) begin
          pulse_cyc.push_back(cyc);
          if (exp_inst.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_inst_valid: got if_inst 0x%08h with nothing pending", bus.if_inst);
          end else begin
            checkOutput("if_inst", bus.if_inst, exp_inst.pop_front());
          end
        end
        if (bus.mc_valid && !prev_mc) begin
          held_addr = bus.mc_addr;
          if (exp_req.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_mc_valid: got mc_addr 0x%08h with no miss predicted", bus.mc_addr);
          end else begin
            checkOutput("mc_addr", bus.mc_addr, exp_req.pop_front());
          end
        end else if (bus.mc_valid) begin
          checkOutput("mc_addr_hold", bus.mc_addr, held_addr);
        end
        if (bus.mc_valid && !bus.jump_flag) begin
          tests++;
          assert (bus.if_pc == prev_pc) else begin
            fails++;
            $display("[TB] FAIL pc_stable_in_miss: got 0x%08h, expected 0x%08h", bus.if_pc, prev_pc);
          end
        end
        prev_mc = bus.mc_valid;
      end
      prev_pc = bus.if_pc;
    end
  end

  initial begin
    logic [31:0] pc, tag;
    int lat, flush_at;
    resetDut();

    mem[32'h0000_1004] = 32'h00A0_0093;
    mem[32'h0000_2004] = 32'h00B0_0113;
    applyStimulus(32'h0000_1004, 5, -1);
    idleCycle();
    applyStimulus(32'h0000_1004, 5, -1);
    idleCycle();
`ifdef ICACHE_STATS_EN
    checkOutput("cold_hit_count", hit_count, 1);
    checkOutput("cold_miss_count", miss_count, 1);
`endif

    resetDut();
    applyStimulus(32'h0000_1004, 2, -1);
    applyStimulus(32'h0000_2004, 3, -1);
    applyStimulus(32'h0000_1004, 1, -1);
    idleCycle();

    applyStimulus(32'h0000_3000, 4, 2);
    idleCycle();
    applyStimulus(32'h0000_3000, 3, -1);
    idleCycle();

    applyStimulus(32'h0000_5000, 3, 3);
    idleCycle();
    applyStimulus(32'h0000_5000, 2, -1);
    applyStimulus(32'h0000_5000, 2, -1);
    idleCycle();
    checkStats();

    streamWithStall(32'h0000_4010);

    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_6000;
    exp_req.push_back(32'h0000_6000);
    @(posedge clk);
    #1;
    checkOutput("midmiss_mc_valid", bus.mc_valid, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_mc_valid", bus.mc_valid, 0);
    resetDut();
    applyStimulus(32'h0000_4010, 2, -1);
    idleCycle();

    for (int n = 0; n < 300; n++) begin
      tag = $urandom_range(0, 3);
      if (tag == 3) tag = $urandom;
      pc = (tag << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      lat = $urandom_range(1, 5);
      flush_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, lat) : -1;
      applyStimulus(pc, lat, flush_at);
      if ($urandom_range(0, 3) == 0) begin
        bus.if_req = 1'b0;
        rdy = ($urandom_range(0, 1) == 0);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    end
    idleCycle();
    idleCycle();

    checkStats();
    checkOutput("exp_inst_drained", exp_inst.size(), 0);
    checkOutput("exp_req_drained", exp_req.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
